multicycle_control_unit: RTL and testbench

Parametrised multi-cycle RISC-V (RV32I subset) controller for the multi-cycle datapath. It replaces the single-cycle decoder with a Moore FSM plus a combinational ALU decoder, sequences each instruction over 3–5 cycles with a shared instruction/data memory, and stalls on a memory ready handshake. Relative to the single-cycle controller it adds full branch conditions, jalr/lui/auipc, and illegal-opcode detection.

---
 rtl/riscv_ctrl_pkg.sv | 79 +++++++
 rtl/mc_alu_decoder.sv | 45 ++++
 rtl/multicycle_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, ALUControl codes and datapath select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JALR,
    S_JAL,
    S_LUI,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_BRANCH,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct fields to ALUControl.
// Serves both the execute states and the branch compare select.
module mc_alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  alu_op_t              alu_op,
  input  logic                 op5,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [3:0] ctrl;

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: begin
        case (funct3[2:1])
          2'b10:   ctrl = ALU_SLT;
          2'b11:   ctrl = ALU_SLTU;
          default: ctrl = ALU_SUB;
        endcase
      end
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctrl = (op5 && funct7) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign alu_control = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style multi-cycle RV32I controller: sequences each instruction over
// 3-5 cycles on a shared memory and stalls on the memory ready handshake.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W    = 4,
  parameter bit MEM_WAIT_EN  = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 instr_done,
  output logic                 illegal_instr
);

  state_t  state, state_next, decode_target;
  alu_op_t alu_op;
  logic    ready, taken, illegal_op;
  logic    pc_write, ir_write, reg_write, mem_write, done, illegal;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  // beq/bge/bgeu are taken on Zero; bne/blt/bltu on !Zero.
  assign taken = (funct3[2] ^ funct3[0]) ? ~Zero : Zero;

  always_comb begin
    decode_target = S_FETCH;
    illegal_op    = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: decode_target = S_MEMADR;
      OP_RTYPE:          decode_target = S_EXECR;
      OP_ITYPE:          decode_target = S_EXECI;
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b01) illegal_op = 1'b1;
        else                      decode_target = S_BRANCH;
      end
      OP_JAL:            decode_target = S_JAL;
      OP_JALR:           decode_target = S_JALR;
      OP_LUI:            decode_target = S_LUI;
      OP_AUIPC:          decode_target = S_ALUWB;
      default:           illegal_op = 1'b1;
    endcase
    if (illegal_op) decode_target = ILLEGAL_TRAP ? S_ERROR : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_write  = ready;
        ir_write  = ready;
        if (ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        state_next = decode_target;
        if (illegal_op && !ILLEGAL_TRAP) begin
          done    = 1'b1;
          illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (ready) begin
          done       = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_BRANCH;
        pc_write   = taken;
        done       = 1'b1;
        state_next = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_JAL;
      end
      // Jumps to the target held in ALUOut while computing the link value.
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_ERROR: illegal = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (ALUControl)
  );

  // Reset must suppress strobes immediately, even mid-stall.
  assign PCWrite       = pc_write  & rst_n;
  assign IRWrite       = ir_write  & rst_n;
  assign RegWrite      = reg_write & rst_n;
  assign MemWrite      = mem_write & rst_n;
  assign instr_done    = done      & rst_n;
  assign illegal_instr = illegal   & rst_n;
  assign ImmSrc        = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: two controllers (trap / skip-as-NOP, 4- and 6-bit ALUControl)
// run directed and random instructions against a per-instruction control-word model.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       adr;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] alu;
    logic       done;
    logic       ill;
  } cw_t;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pcw_a, irw_a, rw_a, mw_a, adr_a, done_a, ill_a;
  logic [1:0] res_a, sa_a, sb_a;
  logic [2:0] imm_a;
  logic [3:0] alu_a;
  logic       pcw_b, irw_b, rw_b, mw_b, adr_b, done_b, ill_b;
  logic [1:0] res_b, sa_b, sb_b;
  logic [2:0] imm_b;
  logic [5:0] alu_b;

  cw_t obs_a, obs_b;
  assign obs_a = {pcw_a, irw_a, rw_a, mw_a, adr_a, res_a, sa_a, sb_a, alu_a, done_a, ill_a};
  assign obs_b = {pcw_b, irw_b, rw_b, mw_b, adr_b, res_b, sa_b, sb_b, alu_b[3:0], done_b, ill_b};

  int  checks = 0;
  int  errors = 0;
  cw_t exp_q[$];
  logic rdy_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTRL_W(4), .MEM_WAIT_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .Zero(zero),
    .mem_ready(mem_ready), .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a),
    .MemWrite(mw_a), .AdrSrc(adr_a), .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a),
    .ImmSrc(imm_a), .ALUControl(alu_a), .instr_done(done_a), .illegal_instr(ill_a)
  );

  multicycle_control_unit #(.ALUCTRL_W(6), .MEM_WAIT_EN(1'b1), .ILLEGAL_TRAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .Zero(zero),
    .mem_ready(mem_ready), .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b),
    .MemWrite(mw_b), .AdrSrc(adr_b), .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b),
    .ImmSrc(imm_b), .ALUControl(alu_b), .instr_done(done_b), .illegal_instr(ill_b)
  );

  function automatic cw_t mk(input int pcw, irw, rw, mw, adr, res, a, b, alu, done, ill);
    mk = {1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(adr), 2'(res), 2'(a), 2'(b), 4'(alu),
          1'(done), 1'(ill)};
  endfunction

  // ALU operation chosen by instruction mnemonic.
  function automatic int model_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o == RTYPE && f7) ? 1 : 0;
      3'd1:    return 7;
      3'd2:    return 5;
      3'd3:    return 6;
      3'd4:    return 4;
      3'd5:    return f7 ? 9 : 8;
      3'd6:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int branch_alu(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1: return 1;
      3'd4, 3'd5: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic int branch_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd1, 3'd4, 3'd6: return z ? 0 : 1;
      default:          return z ? 1 : 0;
    endcase
  endfunction

  function automatic logic [2:0] imm_expected(input logic [6:0] o);
    case (o)
      STORE:       return 3'd1;
      BRANCH:      return 3'd2;
      JAL:         return 3'd3;
      LUI, AUIPC:  return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  task automatic push(input cw_t w, input logic r);
    exp_q.push_back(w);
    rdy_q.push_back(r);
  endtask

  task automatic checkOutput(input string tag, input cw_t ea, input cw_t eb);
    checks++;
    assert (obs_a === ea) else begin
      errors++;
      $error("[TB] FAIL %s dutA: got %h expected %h", tag, obs_a, ea);
    end
    checks++;
    assert (obs_b === eb) else begin
      errors++;
      $error("[TB] FAIL %s dutB: got %h expected %h", tag, obs_b, eb);
    end
    checks++;
    assert (alu_b[5:4] === 2'b00) else begin
      errors++;
      $error("[TB] FAIL %s aluUpper: got %b expected 00", tag, alu_b[5:4]);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("reset", mk(0,0,0,0,0,2,0,2,0,0,0), mk(0,0,0,0,0,2,0,2,0,0,0));
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Builds the expected per-cycle control words for one instruction, then runs it.
  task automatic applyStimulus(input string name, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input int nf, input int nm);
    int dec_idx;
    exp_q.delete();
    rdy_q.delete();
    op = o; funct3 = f3; funct7 = f7; zero = z;
    for (int i = 0; i < nf; i++) push(mk(0,0,0,0,0,2,0,2,0,0,0), 1'b0);
    push(mk(1,1,0,0,0,2,0,2,0,0,0), 1'b1);
    dec_idx = exp_q.size();
    push(mk(0,0,0,0,0,0,1,1,0,0,0), 1'b1);
    case (o)
      LOAD: begin
        push(mk(0,0,0,0,0,0,2,1,0,0,0), 1'b1);
        for (int i = 0; i < nm; i++) push(mk(0,0,0,0,1,0,0,0,0,0,0), 1'b0);
        push(mk(0,0,0,0,1,0,0,0,0,0,0), 1'b1);
        push(mk(0,0,1,0,0,1,0,0,0,1,0), 1'b1);
      end
      STORE: begin
        push(mk(0,0,0,0,0,0,2,1,0,0,0), 1'b1);
        for (int i = 0; i < nm; i++) push(mk(0,0,0,1,1,0,0,0,0,0,0), 1'b0);
        push(mk(0,0,0,1,1,0,0,0,0,1,0), 1'b1);
      end
      RTYPE: begin
        push(mk(0,0,0,0,0,0,2,0,model_alu(o, f3, f7),0,0), 1'b1);
        push(mk(0,0,1,0,0,0,0,0,0,1,0), 1'b1);
      end
      ITYPE: begin
        push(mk(0,0,0,0,0,0,2,1,model_alu(o, f3, f7),0,0), 1'b1);
        push(mk(0,0,1,0,0,0,0,0,0,1,0), 1'b1);
      end
      BRANCH: push(mk(branch_taken(f3, z),0,0,0,0,0,2,0,branch_alu(f3),1,0), 1'b1);
      JAL: begin
        push(mk(1,0,0,0,0,0,1,2,0,0,0), 1'b1);
        push(mk(0,0,1,0,0,0,0,0,0,1,0), 1'b1);
      end
      JALR: begin
        push(mk(0,0,0,0,0,0,2,1,0,0,0), 1'b1);
        push(mk(1,0,0,0,0,0,1,2,0,0,0), 1'b1);
        push(mk(0,0,1,0,0,0,0,0,0,1,0), 1'b1);
      end
      LUI: begin
        push(mk(0,0,0,0,0,0,3,1,0,0,0), 1'b1);
        push(mk(0,0,1,0,0,0,0,0,0,1,0), 1'b1);
      end
      default: push(mk(0,0,1,0,0,0,0,0,0,1,0), 1'b1);
    endcase
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, i), exp_q[i], exp_q[i]);
      if (i == dec_idx && o != RTYPE) begin
        checks++;
        assert (imm_a === imm_expected(o)) else begin
          errors++;
          $error("[TB] FAIL %s immSrc: got %0d expected %0d", name, imm_a, imm_expected(o));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic illegalTest(input string name, input logic [6:0] o, input logic [2:0] f3);
    op = o; funct3 = f3; funct7 = 1'b0; zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, " fetch"}, mk(1,1,0,0,0,2,0,2,0,0,0), mk(1,1,0,0,0,2,0,2,0,0,0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, " decode"}, mk(0,0,0,0,0,0,1,1,0,0,0), mk(0,0,0,0,0,0,1,1,0,1,1));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput({name, " after"}, mk(0,0,0,0,0,0,0,0,0,0,1), mk(0,0,0,0,0,2,0,2,0,0,0));
      @(posedge clk); #1;
    end
    doReset();
  endtask

  initial begin
    logic [2:0] bf [6];
    logic [6:0] ro;
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    $display("[TB] starting");
    doReset();

    applyStimulus("add",      RTYPE,  3'd0, 1'b0, 1'b0, 0, 0);
    applyStimulus("sub",      RTYPE,  3'd0, 1'b1, 1'b0, 0, 0);
    applyStimulus("srai",     ITYPE,  3'd5, 1'b1, 1'b0, 0, 0);
    applyStimulus("lw_stall", LOAD,   3'd2, 1'b0, 1'b0, 2, 3);
    applyStimulus("bne",      BRANCH, 3'd1, 1'b0, 1'b0, 0, 0);
    applyStimulus("bgeu",     BRANCH, 3'd7, 1'b0, 1'b0, 0, 0);
    applyStimulus("jalr",     JALR,   3'd0, 1'b0, 1'b0, 0, 0);
    applyStimulus("sw_stall", STORE,  3'd2, 1'b0, 1'b0, 1, 2);
    applyStimulus("jal",      JAL,    3'd0, 1'b0, 1'b0, 0, 0);
    applyStimulus("lui",      LUI,    3'd0, 1'b0, 1'b0, 0, 0);
    applyStimulus("auipc",    AUIPC,  3'd0, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 8))
        0: ro = LOAD;   1: ro = STORE;  2: ro = RTYPE;
        3: ro = ITYPE;  4: ro = BRANCH; 5: ro = JAL;
        6: ro = JALR;   7: ro = LUI;    default: ro = AUIPC;
      endcase
      f3 = (ro == BRANCH) ? bf[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      applyStimulus($sformatf("rnd%0d", n), ro, f3, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)));
    end

    illegalTest("ill_op", 7'b1111111, 3'd0);
    illegalTest("ill_br", BRANCH, 3'd2);

    op = STORE; funct3 = 3'd2; mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_sw fetch", mk(1,1,0,0,0,2,0,2,0,0,0), mk(1,1,0,0,0,2,0,2,0,0,0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_sw stall", mk(0,0,0,1,1,0,0,0,0,0,0), mk(0,0,0,1,1,0,0,0,0,0,0));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert (mw_a === 1'b0 && mw_b === 1'b0) else begin
      errors++;
      $error("[TB] FAIL rst_sw memWrite: got %b%b expected 00", mw_a, mw_b);
    end
    checkOutput("rst_sw reset", mk(0,0,0,0,0,2,0,2,0,0,0), mk(0,0,0,0,0,2,0,2,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("post_rst", RTYPE, 3'd4, 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
